// File: rtl/robo_pkg.sv
// Shared definitions for the robot movement path.
// acao_t is the 3-bit movement command exchanged between the advance
// controller and the executor. exec_estado_t holds the executor FSM states.
package robo_pkg;

  typedef enum logic [2:0] {
    PARADO = 3'b000,
    ACAO_N = 3'b001,
    ACAO_O = 3'b010,
    ACAO_L = 3'b011,
    ACAO_S = 3'b100
  } acao_t;

  typedef enum logic {
    OCIOSO  = 1'b0,
    MOVENDO = 1'b1
  } exec_estado_t;

  // True for the four direction codes. Parado and codes 101..111 are not moves.
  function automatic logic acao_e_movimento(input logic [2:0] codigo);
    return (codigo == ACAO_N) || (codigo == ACAO_O) ||
           (codigo == ACAO_L) || (codigo == ACAO_S);
  endfunction

endpackage

// File: rtl/temporizador_passo.sv
// Loadable down-counter that times one step.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset, clears the count
//   load   - load valor into the counter (has priority over counting)
//   valor  - value to load
//   zero   - high while the count is zero
// The counter decrements on every edge while non-zero and not loading,
// and rests at zero.
module temporizador_passo #(
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] valor,
  output logic          zero
);

  logic [TW-1:0] contagem;

  always_ff @(posedge clk) begin
    if (reset) begin
      contagem <= '0;
    end else if (load) begin
      contagem <= valor;
    end else if (contagem != '0) begin
      contagem <= contagem - 1'b1;
    end
  end

  assign zero = (contagem == '0);

endmodule

// File: rtl/executor_movimento.sv
// Movement executor: consumes acao commands and moves the robot one cell per
// accepted command on a LARGURA x ALTURA grid, each step lasting PASSO_CICLOS
// clock cycles.
// Ports:
//   clockc3   - system clock, rising edge
//   reset     - synchronous active-high reset
//   acao      - command code (000 parado, 001 N, 010 O, 011 L, 100 S; others parado)
//   pos_x     - current X cell
//   pos_y     - current Y cell
//   ocupado   - step in progress
//   concluido - one-cycle pulse when a step completes
//   colisao   - one-cycle pulse when a command is rejected at the grid edge
//   passos    - completed step count, saturating at 16'hFFFF
//
// Command interface: acao is sampled on every edge while ocupado is low. A
// direction command is either accepted (ocupado rises after that edge) or
// rejected (colisao pulses after that edge). While ocupado is high acao is
// ignored; the producer may hold a command and it is re-sampled on the first
// edge after ocupado falls.
module executor_movimento
  import robo_pkg::*;
#(
  parameter int LARGURA      = 8,
  parameter int ALTURA       = 8,
  parameter int X0           = 0,
  parameter int Y0           = 0,
  parameter int PASSO_CICLOS = 4
) (
  input  logic                       clockc3,
  input  logic                       reset,
  input  logic [2:0]                 acao,
  output logic [$clog2(LARGURA)-1:0] pos_x,
  output logic [$clog2(ALTURA)-1:0]  pos_y,
  output logic                       ocupado,
  output logic                       concluido,
  output logic                       colisao,
  output logic [15:0]                passos
);

  localparam int XW = $clog2(LARGURA);
  localparam int YW = $clog2(ALTURA);
  localparam int TW = $clog2(PASSO_CICLOS) + 1;

  localparam logic [XW-1:0] X_MAX   = XW'(LARGURA - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(ALTURA - 1);
  localparam logic [TW-1:0] T_CARGA = TW'(PASSO_CICLOS - 1);

  exec_estado_t estado, estado_prox;
  acao_t        direcao;
  logic         cmd_valido;
  logic         alvo_ok;
  logic         aceita;
  logic         rejeita;
  logic         completa;
  logic         timer_zero;

  // Step timer: loaded with PASSO_CICLOS-1 on acceptance, so it reaches zero
  // exactly PASSO_CICLOS-1 edges later and the step completes on the edge after.
  temporizador_passo #(
    .TW(TW)
  ) u_timer (
    .clk   (clockc3),
    .reset (reset),
    .load  (aceita),
    .valor (T_CARGA),
    .zero  (timer_zero)
  );

  // Bounds check at acceptance: the target cell must stay inside the grid.
  always_comb begin
    cmd_valido = acao_e_movimento(acao);
    alvo_ok    = 1'b0;
    case (acao)
      ACAO_N:  alvo_ok = (pos_y != Y_MAX);
      ACAO_S:  alvo_ok = (pos_y != '0);
      ACAO_L:  alvo_ok = (pos_x != X_MAX);
      ACAO_O:  alvo_ok = (pos_x != '0);
      default: alvo_ok = 1'b0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clockc3) begin
    if (reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= estado_prox;
    end
  end

  // FSM: next state and per-edge events
  always_comb begin
    estado_prox = estado;
    aceita      = 1'b0;
    rejeita     = 1'b0;
    completa    = 1'b0;
    case (estado)
      OCIOSO: begin
        if (cmd_valido) begin
          if (alvo_ok) begin
            aceita      = 1'b1;
            estado_prox = MOVENDO;
          end else begin
            rejeita = 1'b1;
          end
        end
      end
      MOVENDO: begin
        if (timer_zero) begin
          completa    = 1'b1;
          estado_prox = OCIOSO;
        end
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  // FSM: outputs decoded from state
  always_comb begin
    ocupado = (estado == MOVENDO);
  end

  // Datapath: position, step count and the two event pulses
  always_ff @(posedge clockc3) begin
    if (reset) begin
      pos_x     <= XW'(X0);
      pos_y     <= YW'(Y0);
      passos    <= '0;
      concluido <= 1'b0;
      colisao   <= 1'b0;
      direcao   <= PARADO;
    end else begin
      concluido <= completa;
      colisao   <= rejeita;
      if (aceita) begin
        direcao <= acao_t'(acao);
      end
      if (completa) begin
        case (direcao)
          ACAO_N:  pos_y <= pos_y + 1'b1;
          ACAO_S:  pos_y <= pos_y - 1'b1;
          ACAO_L:  pos_x <= pos_x + 1'b1;
          ACAO_O:  pos_x <= pos_x - 1'b1;
          default: ;
        endcase
        if (passos != 16'hFFFF) begin
          passos <= passos + 16'd1;
        end
      end
    end
  end

endmodule
